// File: rtl/mcu_intc_if.sv
// mcu_intc CPU/peripheral side bundle.
// slave = controller, master = CPU plus peripheral lines.
interface mcu_intc_if #(
  parameter int NIRQ = 8,
  parameter int VW   = 3
);
  logic [NIRQ-1:0] src;
  logic            we;
  logic [1:0]      wsel;
  logic [NIRQ-1:0] wdata;
  logic            ack;
  logic            eoi;
  logic            irq;
  logic [VW-1:0]   vector;
  logic [NIRQ-1:0] mask;
  logic [NIRQ-1:0] pending;
  logic [NIRQ-1:0] in_service;

  modport master (
    output src, we, wsel, wdata, ack, eoi,
    input  irq, vector, mask, pending, in_service
  );

  modport slave (
    input  src, we, wsel, wdata, ack, eoi,
    output irq, vector, mask, pending, in_service
  );
endinterface

// File: rtl/mcu_intc.sv
// mcu_intc: prioritised vectored interrupt controller.
// Index 0 wins; one request held until ack, nesting optional.
module mcu_intc #(
  parameter int              NIRQ = 8,
  parameter int              VW   = 3,
  parameter logic [NIRQ-1:0] EDGE = {NIRQ{1'b1}},
  parameter int              NEST = 1
) (
  input  logic        clock,
  input  logic        reset,
  mcu_intc_if.slave   bus
);

  typedef enum logic {IDLE, REQ} state_e;

  state_e          state_q, state_d;
  logic            irq_q, irq_d;
  logic [VW-1:0]   vector_q, vector_d;
  logic [NIRQ-1:0] mask_q, mask_d;
  logic [NIRQ-1:0] pend_q, pend_d;
  logic [NIRQ-1:0] insv_q, insv_d;
  logic [NIRQ-1:0] src_q, src_d;

  logic [NIRQ-1:0] src_edge;
  logic [NIRQ-1:0] wr_set;
  logic [NIRQ-1:0] wr_clr;
  logic [NIRQ-1:0] ack_hot;
  logic [NIRQ-1:0] insv_low;
  logic [NIRQ-1:0] qual;
  logic [NIRQ-1:0] cand;
  logic [NIRQ-1:0] edge_pend;
  logic [VW-1:0]   best;
  logic            ack_fire;

  always_comb begin
    src_d    = bus.src;
    src_edge = EDGE & bus.src & ~src_q;
    wr_set   = '0;
    wr_clr   = '0;
    mask_d   = mask_q;
    if (bus.we) begin
      unique case (1'b1)
        bus.wsel == 2'd0: mask_d = bus.wdata;
        bus.wsel == 2'd1: wr_clr = bus.wdata;
        bus.wsel == 2'd2: wr_set = bus.wdata;
        default: ;
      endcase
    end

    ack_fire = bus.ack && (state_q == REQ);
    for (int i = 0; i < NIRQ; i++)
      ack_hot[i] = ack_fire && (vector_q == VW'(i));

    // Lowest set in-service bit; minus one gives all strictly-higher priorities.
    insv_low = insv_q & (~insv_q + NIRQ'(1));
    if (NEST != 0)
      qual = insv_low - NIRQ'(1);
    else
      qual = (insv_q == '0) ? '1 : '0;

    cand = pend_q & mask_q & qual;
    best = '0;
    for (int i = NIRQ - 1; i >= 0; i--)
      if (cand[i]) best = VW'(i);

    edge_pend = src_edge | wr_set | (pend_q & ~(wr_clr | ack_hot));
    pend_d    = (EDGE & edge_pend) | (~EDGE & bus.src);

    insv_d = (insv_q & ~(bus.eoi ? insv_low : '0)) | ack_hot;

    state_d  = state_q;
    irq_d    = irq_q;
    vector_d = vector_q;
    unique case (state_q)
      IDLE: begin
        if (|cand) begin
          state_d  = REQ;
          irq_d    = 1'b1;
          vector_d = best;
        end
      end
      REQ: begin
        if (bus.ack) begin
          state_d = IDLE;
          irq_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        irq_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      irq_q    <= 1'b0;
      vector_q <= '0;
      mask_q   <= '0;
      pend_q   <= '0;
      insv_q   <= '0;
      src_q    <= '0;
    end else begin
      state_q  <= state_d;
      irq_q    <= irq_d;
      vector_q <= vector_d;
      mask_q   <= mask_d;
      pend_q   <= pend_d;
      insv_q   <= insv_d;
      src_q    <= src_d;
    end
  end

  assign bus.irq        = irq_q;
  assign bus.vector     = vector_q;
  assign bus.mask       = mask_q;
  assign bus.pending    = pend_q;
  assign bus.in_service = insv_q;

endmodule
